// File: rtl/legv8_control_fsm.sv
// legv8_control_fsm
// Multi-cycle control unit for dataPath_core. It sequences IDLE, FETCH, DECODE,
// EXEC and MEM, and drives the full datapath control word from the current
// state and the instruction register.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   run                 permits leaving IDLE and continuing after each instruction
//   IR_out, status      instruction register and stored {N,Z,C,V} flags
//   alu_z               combinational ALU zero flag (CBZ/CBNZ decision)
//   add_tri_sel         address bus source (1=PC, 0=ALU)
//   data_tri_sel        data bus source (00=ALU, 01=reg B, 11=memory)
//   w_reg, C0, mem_cs, mem_write_en, IR_load, status_load, B_Sel   strobes
//   k, FS, size         immediate, ALU function, access size (always 64-bit)
//   SA, SB, DA          register selects (31 = XZR when idle)
//   PC_sel              00=hold, 01=PC+4, 10=PC+k
//   state, illegal      debug state; one-cycle pulse after an unsupported opcode
//
// Build option: define LEGV8_BCOND_EN to support B.cond; otherwise B.cond is
// retired as an unsupported opcode.
module legv8_control_fsm (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR_out,
  input  logic [3:0]  status,
  input  logic        alu_z,
  output logic        add_tri_sel,
  output logic [1:0]  data_tri_sel,
  output logic        w_reg,
  output logic        C0,
  output logic        mem_cs,
  output logic        mem_write_en,
  output logic        IR_load,
  output logic        status_load,
  output logic        B_Sel,
  output logic [31:0] k,
  output logic [4:0]  FS,
  output logic [1:0]  size,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic [1:0]  PC_sel,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4
  } state_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b01100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b10000;

  // R-type opcodes, index 0..6: ADD, SUB, AND, ORR, EOR, ADDS, SUBS
  localparam logic [76:0] R_OPS = {11'b11101011000, 11'b10101011000, 11'b11001010000,
                                   11'b10101010000, 11'b10001010000, 11'b11001011000,
                                   11'b10001011000};
  // I-type opcodes (IR[31:22]), index 0..3: ADDI, SUBI, ANDI, ORRI
  localparam logic [39:0] I_OPS = {10'b1011001000, 10'b1001001000, 10'b1101000100,
                                   10'b1001000100};

  state_t      state_reg, state_next;
  logic        illegal_reg, illegal_next;
  logic [6:0]  r_hit;
  logic [3:0]  i_hit;
  logic        alu_r, alu_i, is_ldur, is_stur, is_mem, is_b, is_cbz, is_cbnz;
  logic        bcond_hit, cond_taken, supported;
  logic [4:0]  fs_alu;
  logic [31:0] k_imm12, k_d, k_b, k_cb;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_r_dec
      assign r_hit[gi] = (IR_out[31:21] == R_OPS[gi*11 +: 11]);
    end
    for (gi = 0; gi < 4; gi++) begin : g_i_dec
      assign i_hit[gi] = (IR_out[31:22] == I_OPS[gi*10 +: 10]);
    end
  endgenerate

  assign alu_r   = |r_hit;
  assign alu_i   = |i_hit;
  assign is_ldur = (IR_out[31:21] == 11'b11111000010);
  assign is_stur = (IR_out[31:21] == 11'b11111000000);
  assign is_mem  = is_ldur | is_stur;
  assign is_b    = (IR_out[31:26] == 6'b000101);
  assign is_cbz  = (IR_out[31:24] == 8'b10110100);
  assign is_cbnz = (IR_out[31:24] == 8'b10110101);

`ifdef LEGV8_BCOND_EN
  logic flag_n, flag_z, flag_c, flag_v, cond_base;
  assign {flag_n, flag_z, flag_c, flag_v} = status;
  assign bcond_hit = (IR_out[31:24] == 8'b01010100);

  // IR[3:1] picks the base test, IR[0] inverts it (except for the always pair).
  always_comb begin
    cond_base = 1'b1;
    case (IR_out[3:1])
      3'b000: cond_base = flag_z;
      3'b001: cond_base = flag_c;
      3'b010: cond_base = flag_n;
      3'b011: cond_base = flag_v;
      3'b100: cond_base = flag_c & ~flag_z;
      3'b101: cond_base = (flag_n == flag_v);
      3'b110: cond_base = ~flag_z & (flag_n == flag_v);
      default: cond_base = 1'b1;
    endcase
  end
  assign cond_taken = (IR_out[0] && (IR_out[3:1] != 3'b111)) ? ~cond_base : cond_base;
`else
  logic unused_status;
  assign unused_status = ^status;
  assign bcond_hit     = 1'b0;
  assign cond_taken    = 1'b0;
`endif

  assign supported = alu_r | alu_i | is_mem | is_b | is_cbz | is_cbnz | bcond_hit;

  assign k_imm12 = {20'd0, IR_out[21:10]};
  assign k_d     = {{23{IR_out[20]}}, IR_out[20:12]};
  assign k_b     = {{4{IR_out[25]}}, IR_out[25:0], 2'b00};
  assign k_cb    = {{11{IR_out[23]}}, IR_out[23:5], 2'b00};

  always_comb begin
    fs_alu = FS_ADD;
    if (r_hit[1] | r_hit[6] | i_hit[1])      fs_alu = FS_SUB;
    else if (r_hit[2] | i_hit[2])            fs_alu = FS_AND;
    else if (r_hit[3] | i_hit[3])            fs_alu = FS_ORR;
    else if (r_hit[4])                       fs_alu = FS_EOR;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = 1'b0;
    add_tri_sel  = 1'b0;
    data_tri_sel = 2'b00;
    w_reg        = 1'b0;
    C0           = 1'b0;
    mem_cs       = 1'b0;
    mem_write_en = 1'b0;
    IR_load      = 1'b0;
    status_load  = 1'b0;
    B_Sel        = 1'b0;
    k            = 32'd0;
    FS           = 5'b00000;
    SA           = 5'd31;
    SB           = 5'd31;
    DA           = 5'd31;
    PC_sel       = 2'b00;

    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        add_tri_sel = 1'b1;
        mem_cs      = 1'b1;
        IR_load     = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (alu_r || alu_i) begin
          SA          = IR_out[9:5];
          SB          = IR_out[20:16];
          DA          = IR_out[4:0];
          B_Sel       = alu_i;
          k           = alu_i ? k_imm12 : 32'd0;
          FS          = fs_alu;
          C0          = (fs_alu == FS_SUB);
          w_reg       = 1'b1;
          status_load = r_hit[5] | r_hit[6];
          PC_sel      = 2'b01;
        end else if (is_mem) begin
          // Address computation only; the PC advances when MEM retires.
          SA    = IR_out[9:5];
          B_Sel = 1'b1;
          k     = k_d;
          FS    = FS_ADD;
        end else if (is_b) begin
          k      = k_b;
          PC_sel = 2'b10;
        end else if (is_cbz || is_cbnz) begin
          // XZR | Rt puts Rt's zero-ness on alu_z.
          SB     = IR_out[4:0];
          FS     = FS_ORR;
          k      = k_cb;
          PC_sel = ((is_cbz && alu_z) || (is_cbnz && !alu_z)) ? 2'b10 : 2'b01;
        end else if (bcond_hit) begin
          k      = k_cb;
          PC_sel = cond_taken ? 2'b10 : 2'b01;
        end else begin
          PC_sel       = 2'b01;
          illegal_next = 1'b1;
        end
        if (is_mem)   state_next = S_MEM;
        else if (run) state_next = S_FETCH;
        else          state_next = S_IDLE;
      end
      S_MEM: begin
        SA     = IR_out[9:5];
        B_Sel  = 1'b1;
        k      = k_d;
        FS     = FS_ADD;
        mem_cs = 1'b1;
        PC_sel = 2'b01;
        if (is_ldur) begin
          data_tri_sel = 2'b11;
          DA           = IR_out[4:0];
          w_reg        = 1'b1;
        end else begin
          data_tri_sel = 2'b01;
          SB           = IR_out[4:0];
          mem_write_en = 1'b1;
        end
        state_next = run ? S_FETCH : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // The cycle in which reset is sampled must not commit anything.
    if (reset) begin
      w_reg        = 1'b0;
      mem_write_en = 1'b0;
      status_load  = 1'b0;
      IR_load      = 1'b0;
      PC_sel       = 2'b00;
    end
  end

  assign size    = 2'b11;
  assign state   = state_reg;
  assign illegal = illegal_reg;

endmodule
